// File: rtl/divider.sv
// Unsigned restoring divider: a 2*bits dividend divided by a bits divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are detected up front and finish in a single cycle.
module divider #(
    parameter int bits = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2*bits-1:0]   dividend,
    input  logic [bits-1:0]     divisor,
    output logic                busy,
    output logic                done,
    output logic [bits-1:0]     quotient,
    output logic [bits-1:0]     remainder,
    output logic                C,
    output logic                Z,
    output logic                V,
    output logic                N,
    output logic                div_zero
);

    localparam int cntw = $clog2(bits) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [bits-1:0]   divisor_q;
    logic [bits:0]     part_rem;
    logic [bits-1:0]   shift_reg;
    logic [cntw-1:0]   step;
    logic              dz_flag;

    logic              accept;
    logic              is_zero;
    logic              is_ovf;
    logic              last_step;
    logic [bits+1:0]   trial;
    logic [bits+1:0]   diff;
    logic              fits;
    logic [bits:0]     rem_next;
    logic [bits-1:0]   shift_next;

    assign accept    = (state == IDLE) && start;
    assign is_zero   = (divisor == '0);
    assign is_ovf    = (dividend[2*bits-1:bits] >= divisor);
    assign last_step = (state == RUN) && (step == cntw'(bits - 1));

    // The partial remainder is always below the divisor, so the shifted trial value
    // fits in bits+1; one extra bit on top turns the subtraction borrow into the compare.
    assign trial      = {part_rem, shift_reg[bits-1]};
    assign diff       = trial - {2'b00, divisor_q};
    assign fits       = ~diff[bits+1];
    assign rem_next   = fits ? diff[bits:0] : trial[bits:0];
    assign shift_next = {shift_reg[bits-2:0], fits};

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign div_zero = done && dz_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (is_zero || is_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // shift_reg starts as the dividend low half and fills with quotient bits from the LSB
    always_ff @(posedge clk) begin
        if (reset) begin
            divisor_q <= '0;
            part_rem  <= '0;
            shift_reg <= '0;
            step      <= '0;
            quotient  <= '0;
            remainder <= '0;
            C         <= 1'b0;
            Z         <= 1'b0;
            V         <= 1'b0;
            N         <= 1'b0;
            dz_flag   <= 1'b0;
        end else if (accept) begin
            divisor_q <= divisor;
            part_rem  <= {1'b0, dividend[2*bits-1:bits]};
            shift_reg <= dividend[bits-1:0];
            step      <= '0;
            if (is_zero) begin
                C       <= 1'b0;
                Z       <= 1'b0;
                V       <= 1'b0;
                N       <= 1'b0;
                dz_flag <= 1'b1;
            end else if (is_ovf) begin
                C       <= 1'b0;
                Z       <= 1'b0;
                V       <= 1'b1;
                N       <= 1'b0;
                dz_flag <= 1'b0;
            end
        end else if (state == RUN) begin
            part_rem  <= rem_next;
            shift_reg <= shift_next;
            step      <= step + 1'b1;
            if (last_step) begin
                quotient  <= shift_next;
                remainder <= rem_next[bits-1:0];
                N         <= shift_next[bits-1];
                Z         <= (shift_next == '0);
                V         <= 1'b0;
                C         <= 1'b0;
                dz_flag   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: expected results are queued when a divide is started
// and compared when done appears.
module tb_divider;

    typedef struct {
        int          lat;
        logic [15:0] q;
        logic [15:0] r;
        logic [4:0]  flags;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        C;
    logic        Z;
    logic        V;
    logic        N;
    logic        div_zero;

    exp_t        sb[$];
    int          checks;
    int          errors;
    logic [15:0] prevQ;
    logic [15:0] prevR;

    divider #(.bits(16)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .C(C),
        .Z(Z),
        .V(V),
        .N(N),
        .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Queue the model result, then present the operands for exactly one accepting edge.
    task automatic applyStimulus(input logic [31:0] dvd, input logic [15:0] dvs);
        exp_t        e;
        logic [31:0] q32;
        logic [31:0] r32;
        if (dvs == 16'd0) begin
            e.lat = 0; e.q = prevQ; e.r = prevR; e.flags = 5'b00001;
        end else if (dvd[31:16] >= dvs) begin
            e.lat = 0; e.q = prevQ; e.r = prevR; e.flags = 5'b00100;
        end else begin
            q32     = dvd / {16'h0000, dvs};
            r32     = dvd % {16'h0000, dvs};
            e.lat   = 16;
            e.q     = q32[15:0];
            e.r     = r32[15:0];
            e.flags = {1'b0, (q32[15:0] == 16'd0), 1'b0, q32[15], 1'b0};
            prevQ   = q32[15:0];
            prevR   = r32[15:0];
        end
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        int   cnt;
        e = sb.pop_front();
        @(negedge clk);
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'(e.lat));
        chk({tag, "_quotient"}, 64'(quotient), 64'(e.q));
        chk({tag, "_remainder"}, 64'(remainder), 64'(e.r));
        chk({tag, "_flags_CZVNdz"}, 64'({C, Z, V, N, div_zero}), 64'(e.flags));
        @(negedge clk);
        chk({tag, "_done_busy_after"}, 64'({done, busy}), 64'(2'b00));
    endtask

    initial begin
        logic sawDone;
        checks   = 0;
        errors   = 0;
        prevQ    = 16'h0000;
        prevR    = 16'h0000;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 32'h0;
        divisor  = 16'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 64'({busy, done, quotient, remainder, C, Z, V, N, div_zero}), 64'd0);

        applyStimulus(32'h000186A0, 16'd7);
        checkOutput("div_100000_by_7");
        applyStimulus(32'd5, 16'd10);
        checkOutput("div_5_by_10");
        applyStimulus(32'h00008000, 16'd1);
        checkOutput("div_8000_by_1");
        applyStimulus(32'h00001234, 16'd0);
        checkOutput("div_by_zero");
        applyStimulus(32'h00070000, 16'd7);
        checkOutput("overflow_equal");
        applyStimulus(32'hFFFE0001, 16'hFFFF);
        checkOutput("div_max_square");
        applyStimulus(32'h7FFFFFFF, 16'h8000);
        checkOutput("div_carry_stress");

        // Reset lands on RUN step 8; a divide-by-zero start is offered while busy.
        applyStimulus(32'd123456, 16'd321);
        sawDone = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) sawDone = 1'b1;
            start   = (k == 3);
            divisor = (k == 3) ? 16'd0 : 16'd321;
            reset   = (k == 8);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("no_done_before_reset", 64'(sawDone), 64'd0);
        chk("outputs_after_midrun_reset",
            64'({busy, done, quotient, remainder, C, Z, V, N, div_zero}), 64'd0);
        void'(sb.pop_front());
        prevQ = 16'h0000;
        prevR = 16'h0000;
        sawDone = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
        end
        chk("idle_after_reset", 64'(sawDone), 64'd0);

        applyStimulus(32'd1000000, 16'd999);
        checkOutput("div_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have parameter: bits, 16, quotient/divisor/remainder width; dividend is 2*bits wide.
REQ-002 The block SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port: start  input  1  request to begin a division; sampled only when busy=0.
REQ-005 The block SHALL have port: dividend  input  2*bits  unsigned dividend; sampled with start.
REQ-006 The block SHALL have port: divisor  input  bits  unsigned divisor; sampled with start.
REQ-007 The block SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-008 The block SHALL have port: done  output  1  one-cycle completion pulse.
REQ-009 The block SHALL have ports: quotient  output  bits; remainder  output  bits; registered results.
REQ-010 The block SHALL have ports: C, Z, V, N  output  1 each  registered condition flags.
REQ-011 The block SHALL have port: div_zero  output  1  high with done when divisor was 0.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; busy = (state != IDLE).
REQ-013 In IDLE, start=1 at edge E0 SHALL latch dividend and divisor and exit IDLE; start while busy SHALL be ignored.
REQ-014 If divisor==0 at E0, the FSM SHALL go to DONE: div_zero=1, N=Z=V=C=0, quotient and remainder unchanged.
REQ-015 Else if dividend[2*bits-1:bits] >= divisor at E0 (overflow), the FSM SHALL go to DONE: V=1, N=Z=C=0, div_zero=0, quotient and remainder unchanged.
REQ-016 Otherwise the FSM SHALL enter RUN: partial remainder = dividend high half; step counter = 0.
REQ-017 Each RUN edge SHALL perform one restoring step: shift the next dividend low-half bit (MSB first) into a bits+1-wide partial remainder; if the partial remainder >= divisor, subtract and set the quotient bit to 1, else 0.
REQ-018 After exactly bits RUN steps (edge E(bits)), the FSM SHALL load quotient and remainder, set N=quotient[bits-1], Z=(quotient==0), V=0, C=0, div_zero=0, and enter DONE.
REQ-019 Latency: done SHALL be high only in the cycle after E(bits) for a normal divide, and only in the cycle after E0 for zero or overflow.
REQ-020 DONE SHALL last exactly one cycle, then IDLE; done and div_zero SHALL be low in all other states.
REQ-021 A start coincident with DONE SHALL be ignored; the earliest next accept SHALL be the edge after IDLE is re-entered.
REQ-022 quotient, remainder and flags SHALL hold their values until the next completion or reset.
REQ-023 The arithmetic SHALL be unsigned; the intermediate compare/subtract SHALL be bits+1 wide so no step can lose a carry.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE and clear busy, done, quotient, remainder, C, Z, V, N and div_zero to 0, with priority over start and any in-flight division.
REQ-025 A division interrupted by reset SHALL produce no done pulse and SHALL leave no partial result visible.

Verification
REQ-026 Bench: dividend=0x000186A0, divisor=7 -> done exactly 16 edges after start; quotient=0x37CD, remainder=5; N=Z=V=C=0.
REQ-027 Bench: dividend=5, divisor=10 -> quotient=0, remainder=5, Z=1, N=0.
REQ-028 Bench: dividend=0x00008000, divisor=1 -> quotient=0x8000, remainder=0, N=1, Z=0.
REQ-029 Bench: divisor=0 -> done and div_zero high in the cycle after start; quotient and remainder keep their prior values; flags=0.
REQ-030 Bench: dividend=0x00070000, divisor=7 -> V=1 with done in the cycle after start; quotient and remainder unchanged.
REQ-031 Bench: reset asserted on RUN step 8, with start pulsed during busy -> all outputs 0, no done pulse, the second start ignored; a fresh divide after reset gives correct results.
